// File: rtl/bram_cmd_fifo_pkg.sv
// Shared types and sizing helpers for the Bram-backed command FIFO.
// Default widths: Bram address 8 bits, command word 64 bits.
package bram_cmd_fifo_pkg;

  localparam int unsigned BYTE_BITS  = 8;
  localparam int unsigned QWORD_BITS = 64;

  typedef logic [QWORD_BITS-1:0] cmd_word_t;

  // Encodings equal the skid occupancy so the state doubles as a count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic int unsigned count_bits(input int unsigned addr_bits);
    return addr_bits + 2;
  endfunction

endpackage

// File: rtl/bram_cmd_fifo_if.sv
// Ready/valid handshake bundle between command parser, FIFO and plot stage.
interface bram_cmd_fifo_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 64
) ();

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_ready;
  logic [ADDR_BITS+1:0] count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/bram_cmd_fifo_bram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module bram_cmd_fifo_bram #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (clear)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bram_cmd_fifo.sv
// Ready/valid FWFT FIFO over a Bram with a 2-entry skid hiding read latency.
// Optional BRAM_CMD_FIFO_WATERMARK_EN adds max_count and overflow_seen.
module bram_cmd_fifo
  import bram_cmd_fifo_pkg::*;
#(
  parameter int unsigned ADDR_BITS = BYTE_BITS,
  parameter int unsigned DATA_BITS = QWORD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  bram_cmd_fifo_if.slave       bus
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
  ,
  output logic [ADDR_BITS+1:0] max_count,
  output logic                 overflow_seen
`endif
);

  localparam int unsigned CW = count_bits(ADDR_BITS);
  localparam logic [ADDR_BITS:0] DEPTH_V = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS:0]   wr_ptr;
  logic [ADDR_BITS:0]   rd_ptr;
  logic [ADDR_BITS:0]   mem_count;
  logic                 rd_pend;
  skid_state_t          state;
  logic [DATA_BITS-1:0] skid_head;
  logic [DATA_BITS-1:0] skid_tail;
  logic [DATA_BITS-1:0] rd_data;
  logic [1:0]           occ;
  logic [1:0]           occ_next;
  logic                 in_rdy;
  logic                 out_vld;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [CW-1:0]        count_int;

  assign mem_count = wr_ptr - rd_ptr;
  assign in_rdy    = (mem_count != DEPTH_V) && !clear;
  assign out_vld   = (state != EMPTY);
  assign push      = bus.in_valid && in_rdy;
  assign pop       = out_vld && bus.out_ready;
  assign occ       = state;
  assign occ_next  = occ - {1'b0, pop};

  // Only issue if the word can land in the skid once the pending one is in.
  assign issue = (mem_count != '0) && ((occ_next + {1'b0, rd_pend}) < 2'd2);

  assign count_int = CW'(mem_count) + CW'(occ) + CW'(rd_pend);

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = skid_head;
  assign bus.count     = count_int;

  bram_cmd_fifo_bram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) storage (
    .clk     (clk),
    .clear   (1'b0),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_BITS-1:0]),
    .wr_data (bus.in_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr[ADDR_BITS-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      rd_pend <= issue;
    end
  end

  // Skid FSM: rd_pend means Bram rd_data holds a word to capture this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      skid_head <= '0;
      skid_tail <= '0;
    end else if (clear) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (rd_pend) begin
            skid_head <= rd_data;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({rd_pend, pop})
            2'b10: begin
              skid_tail <= rd_data;
              state     <= TWO;
            end
            2'b11: skid_head <= rd_data;
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            skid_head <= skid_tail;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef BRAM_CMD_FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_count     <= '0;
      overflow_seen <= 1'b0;
    end else if (clear) begin
      max_count     <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (count_int > max_count) max_count <= count_int;
      if (bus.in_valid && !in_rdy) overflow_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_cmd_fifo.sv
// Scoreboard bench for bram_cmd_fifo with a 4-deep Bram (capacity 6).
module tb_bram_cmd_fifo;

  localparam int unsigned AB = 2;
  localparam int unsigned DB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  bram_cmd_fifo_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

`ifdef BRAM_CMD_FIFO_WATERMARK_EN
  logic [AB+1:0] max_count;
  logic          overflow_seen;
`endif

  bram_cmd_fifo #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .bus           (bus)
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
    ,
    .max_count     (max_count),
    .overflow_seen (overflow_seen)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DB-1:0] sb [$];
  bit rand_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input logic [31:0] act, input int lim);
    n_cmp++;
    if (act > lim) begin
      n_err++;
      $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
    end
  endtask

  // Monitor: accepted pushes enter the scoreboard, presented pops are checked.
  always @(negedge clk) begin
    if (reset || clear) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word", bus.out_data);
        end else begin
          chk("pop_data", bus.out_data, sb.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  task automatic push_word(input logic [DB-1:0] d);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got in_ready=0, expected acceptance of 0x%0h", d);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int w = 0; w < 1000 && sb.size() != 0; w++) @(negedge clk);
    chk({tag, "_sb_left"}, sb.size(), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_count"}, bus.count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rand_phase) begin
      #1;
      bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    int acc;
    int refused_at;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_count", bus.count, 0);
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
    chk("rst_max_count", max_count, 0);
    chk("rst_overflow", overflow_seen, 0);
`endif

    // Fill with out_ready low: 4 words in Bram plus 2 in the skid.
    @(posedge clk);
    #1;
    acc = 0;
    refused_at = -1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DB'(16'h00A0 + i);
      @(negedge clk);
      if (bus.in_ready) acc++;
      else if (refused_at < 0) refused_at = i;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_accepted", acc, 6);
    chk("full_refused_idx", refused_at, 6);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_count", bus.count, 6);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_out_data", bus.out_data, 16'h00A0);
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
    chk("full_max_count", max_count, 6);
    chk("full_overflow", overflow_seen, 1);
`endif
    @(posedge clk);
    #1;
    drain("full");

    // Single word latency: out_valid appears two edges after the push edge.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push_word(16'h0055);
    @(negedge clk);
    chk("lat_valid_t0", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid_t1", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid_t2", bus.out_valid, 1);
    chk("lat_data", bus.out_data, 16'h0055);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("lat_pop_valid", bus.out_valid, 0);
    chk("lat_pop_count", bus.count, 0);
    chk("lat_hold_data", bus.out_data, 16'h0055);

    // Streaming: one in Bram, one in flight, one in the skid at most.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 32; i++) push_word(DB'(i));
      end
      begin
        @(negedge clk);
        for (int w = 0; w < 10 && !bus.out_valid; w++) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
          chk("stream_no_gap", bus.out_valid, 1);
          chk_le("stream_count", bus.count, 3);
          @(negedge clk);
        end
      end
    join
    drain("stream");

    // Random back-pressure across many pointer wraps.
    @(posedge clk);
    #1;
    rand_phase = 1;
    for (int i = 0; i < 200; i++) push_word(DB'(16'h0100 + i));
    rand_phase = 0;
    @(posedge clk);
    #2;
    drain("rand");

    // Clear with a simultaneous push: both the stored words and 0x77 vanish.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DB'(16'h00B0 + i));
    @(negedge clk);
    chk("clr_pre_count", bus.count, 5);
    @(posedge clk);
    #1;
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0077;
    @(negedge clk);
    chk("clr_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_count", bus.count, 0);
    chk("clr_out_valid", bus.out_valid, 0);
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
    chk("clr_max_count", max_count, 0);
    chk("clr_overflow", overflow_seen, 0);
`endif
    @(posedge clk);
    #1;
    push_word(16'h0012);
    drain("clr_after");

    // Asynchronous reset while a Bram read is in flight.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DB'(16'h0200 + i));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_count", bus.count, 0);
`ifdef BRAM_CMD_FIFO_WATERMARK_EN
    chk("arst_max_count", max_count, 0);
    chk("arst_overflow", overflow_seen, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    push_word(16'h003C);
    drain("arst_after");

    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
